// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage with a valid/ready imem port, bounded in-flight requests and a
// prefetch queue feeding registered if_id_* outputs; redirects flush and drop stale responses.
module fetch_prefetch_unit #(
  parameter int                XLEN       = 32,
  parameter int                ADDR_W     = 32,
  parameter int                QDEPTH     = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = 'h40
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ex_if_stall,
  input  logic                      id_if_selpcsource,
  input  logic [1:0]                id_if_selpctype,
  input  logic [ADDR_W-1:0]         id_if_rega,
  input  logic [ADDR_W-1:0]         id_if_pcimd2ext,
  input  logic [ADDR_W-1:0]         id_if_pcindex,
  output logic                      imem_req_valid,
  input  logic                      imem_req_ready,
  output logic [ADDR_W-1:0]         imem_req_addr,
  input  logic                      imem_rsp_valid,
  input  logic [XLEN-1:0]           imem_rsp_data,
  output logic [XLEN-1:0]           if_id_instruc,
  output logic [ADDR_W-1:0]         if_id_nextpc,
  output logic                      if_id_valid,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [XLEN-1:0]   data;
  } q_entry_t;

  q_entry_t [QDEPTH-1:0] q_mem_q, q_mem_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         drop_cnt_q, drop_cnt_d;
  logic [ADDR_W-1:0]     fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]     resp_pc_q, resp_pc_d;
  logic [XLEN-1:0]       instruc_q, instruc_d;
  logic [ADDR_W-1:0]     nextpc_q, nextpc_d;
  logic                  valid_q, valid_d;

  logic [CW-1:0]         in_use;
  logic                  fire, redirect, drop_rsp, push, pop;
  logic [ADDR_W-1:0]     target;
  q_entry_t              head;

  always_comb begin
    // Queue slots plus in-flight requests never exceed QDEPTH, so a push can never overflow.
    in_use         = count_q + outstanding_q;
    imem_req_valid = reset & (in_use < CW'(QDEPTH));
    imem_req_addr  = fetch_pc_q;
    fire           = imem_req_valid & imem_req_ready;
    redirect       = id_if_selpcsource & ~ex_if_stall;
    drop_rsp       = imem_rsp_valid & (drop_cnt_q != '0);
    push           = imem_rsp_valid & ~drop_rsp & ~redirect;
    pop            = ~ex_if_stall & ~redirect & (count_q != '0);
    head           = q_mem_q[rd_ptr_q];

    unique case (id_if_selpctype)
      2'b00:   target = id_if_pcimd2ext;
      2'b01:   target = id_if_rega;
      2'b10:   target = id_if_pcindex;
      default: target = EXC_VECTOR;
    endcase
  end

  always_comb begin
    q_mem_d       = q_mem_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q + CW'(fire) - CW'(imem_rsp_valid);
    drop_cnt_d    = drop_cnt_q - CW'(drop_rsp);
    fetch_pc_d    = fire ? fetch_pc_q + ADDR_W'(4) : fetch_pc_q;
    resp_pc_d     = push ? resp_pc_q + ADDR_W'(4) : resp_pc_q;
    instruc_d     = '0;
    nextpc_d      = nextpc_q;
    valid_d       = 1'b0;

    if (push) begin
      q_mem_d[wr_ptr_q] = '{pc: resp_pc_q, data: imem_rsp_data};
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PW'(1);
      instruc_d = head.data;
      nextpc_d  = head.pc + ADDR_W'(4);
      valid_d   = 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);

    // Everything still in flight after this edge, including a same-cycle fire, is stale.
    if (redirect) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      drop_cnt_d = outstanding_d;
      fetch_pc_d = target;
      resp_pc_d  = target;
      nextpc_d   = target;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_mem_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      instruc_q     <= '0;
      nextpc_q      <= '0;
      valid_q       <= 1'b0;
    end else begin
      q_mem_q       <= q_mem_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      instruc_q     <= instruc_d;
      nextpc_q      <= nextpc_d;
      valid_q       <= valid_d;
    end
  end

  assign if_id_instruc = instruc_q;
  assign if_id_nextpc  = nextpc_q;
  assign if_id_valid   = valid_q;
  assign q_count       = count_q;

endmodule
